// File: rtl/count_monitor.sv
// count_monitor
// Observer for a counter's parallel output. Each accepted sample reseeds a
// +1/-1 prediction. A run of consistent samples locks the monitor. Once
// locked, every discontinuity is pulsed, counted (saturating) and captured.
module count_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] count_in,
    input  logic             dir_up,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_bad,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

    state_e           state_r;
    state_e           state_nx_s;
    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] expected_nx_s;
    logic [3:0]       match_cnt_r;
    logic [3:0]       match_cnt_nx_s;
    logic [3:0]       match_inc_s;
    logic             match_s;
    logic             err_hit_s;
    logic             locked_r;
    logic             err_pulse_r;
    logic [ERR_W-1:0] err_count_r;
    logic [ERR_W-1:0] err_count_nx_s;
    logic [WIDTH-1:0] last_bad_r;
    logic [WIDTH-1:0] last_bad_nx_s;

    // Next expected value: one step in the sampled direction, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] predict_next(input logic [WIDTH-1:0] value,
                                                      input logic             up);
        logic [WIDTH-1:0] result;
        if (up) begin
            result = value + WIDTH'(1);
        end else begin
            result = value - WIDTH'(1);
        end
        return result;
    endfunction

    // Saturating increment so a long fault storm never wraps the counter back to zero.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == {ERR_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + ERR_W'(1);
        end
        return result;
    endfunction

    assign match_s     = (count_in == expected_r);
    assign match_inc_s = match_cnt_r + 4'd1;

    // Next-state, prediction and run-length logic; invalid cycles leave everything unchanged.
    always_comb begin
        state_nx_s     = state_r;
        expected_nx_s  = expected_r;
        match_cnt_nx_s = match_cnt_r;
        err_hit_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sample_valid) begin
                    expected_nx_s  = predict_next(count_in, dir_up);
                    match_cnt_nx_s = 4'd1;
                    state_nx_s     = ST_ACQUIRE;
                end else begin
                    state_nx_s     = ST_IDLE;
                end
            end
            ST_ACQUIRE: begin
                if (sample_valid) begin
                    expected_nx_s = predict_next(count_in, dir_up);
                    if (match_s) begin
                        match_cnt_nx_s = match_inc_s;
                        if (match_inc_s >= 4'(LOCK_CNT)) begin
                            state_nx_s = ST_LOCKED;
                        end else begin
                            state_nx_s = ST_ACQUIRE;
                        end
                    end else begin
                        // A mismatch while acquiring restarts the run with this sample as seed.
                        match_cnt_nx_s = 4'd1;
                        state_nx_s     = ST_ACQUIRE;
                    end
                end else begin
                    state_nx_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (sample_valid) begin
                    expected_nx_s = predict_next(count_in, dir_up);
                    if (match_s) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        err_hit_s      = 1'b1;
                        match_cnt_nx_s = 4'd1;
                        state_nx_s     = ST_ACQUIRE;
                    end
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                // Encoding 3 is never entered legitimately; recover to IDLE.
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Error bookkeeping: clear_err overrides a coincident increment/capture.
    always_comb begin
        err_count_nx_s = err_count_r;
        last_bad_nx_s  = last_bad_r;
        if (clear_err) begin
            err_count_nx_s = {ERR_W{1'b0}};
            last_bad_nx_s  = {WIDTH{1'b0}};
        end else if (err_hit_s) begin
            err_count_nx_s = sat_inc(err_count_r);
            last_bad_nx_s  = count_in;
        end else begin
            err_count_nx_s = err_count_r;
            last_bad_nx_s  = last_bad_r;
        end
    end

    // State, prediction and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            expected_r  <= {WIDTH{1'b0}};
            match_cnt_r <= 4'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
            last_bad_r  <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            expected_r  <= expected_nx_s;
            match_cnt_r <= match_cnt_nx_s;
            locked_r    <= (state_nx_s == ST_LOCKED);
            err_pulse_r <= err_hit_s;
            err_count_r <= err_count_nx_s;
            last_bad_r  <= last_bad_nx_s;
        end
    end

    assign state     = state_r;
    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;
    assign last_bad  = last_bad_r;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: a sample-level reference model is
// compared against the DUT every cycle, with directed scenarios that pin
// literal values and a randomized phase.
module tb_count_monitor;

    localparam int WIDTH    = 8;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;

    logic             clk;
    logic             rst;
    logic             sample_valid;
    logic [WIDTH-1:0] count_in;
    logic             dir_up;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_bad;
    logic [1:0]       state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Reference model: mode 0 idle, 1 acquiring, 2 locked.
    int         m_mode  = 0;
    int         m_exp   = 0;
    int         m_run   = 0;
    bit         m_pulse = 1'b0;
    int         m_errs  = 0;
    int         m_last  = 0;

    count_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .dir_up       (dir_up),
        .clear_err    (clear_err),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .last_bad     (last_bad),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on every rising edge from the applied inputs.
    always @(posedge clk) begin
        bit hit;
        m_pulse = 1'b0;
        if (rst) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_errs = 0; m_last = 0;
        end else begin
            if (sample_valid) begin
                hit = (int'(count_in) == m_exp);
                if (m_mode == 0) begin
                    m_mode = 1; m_run = 1;
                end else if (m_mode == 1) begin
                    if (hit) begin
                        m_run = m_run + 1;
                        if (m_run >= LOCK_CNT) m_mode = 2;
                    end else begin
                        m_run = 1;
                    end
                end else begin
                    if (!hit) begin
                        m_pulse = 1'b1;
                        m_mode  = 1;
                        m_run   = 1;
                        if (!clear_err) begin
                            m_errs = (m_errs < 255) ? m_errs + 1 : 255;
                            m_last = int'(count_in);
                        end
                    end
                end
                m_exp = (int'(count_in) + (dir_up ? 1 : 255)) % 256;
            end
            if (clear_err) begin
                m_errs = 0; m_last = 0;
            end
        end
    end

    // Lockstep comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("state",     32'(state),     32'(m_mode));
            chk("locked",    32'(locked),    32'(m_mode == 2));
            chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
            chk("err_count", 32'(err_count), 32'(m_errs));
            chk("last_bad",  32'(last_bad),  32'(m_last));
        end
    end

    task automatic step(input bit r, input bit v, input logic [7:0] c, input bit d, input bit clr);
        rst = r; sample_valid = v; count_in = c; dir_up = d; clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] c, input bit d);
        step(1'b0, 1'b1, c, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] g;
        bit pulse_seen;
        rst = 1'b1; sample_valid = 1'b0; count_in = 8'h00; dir_up = 1'b1; clear_err = 1'b0;

        // Reset and idle
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk_on = 1'b1;
        pulse_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle();
            pulse_seen = pulse_seen | err_pulse;
        end
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_locked", 32'(locked), 32'd0);
        chk("idle_errs", 32'(err_count), 32'd0);
        chk("idle_last", 32'(last_bad), 32'd0);
        chk("idle_pulse", 32'(pulse_seen), 32'd0);

        // Lock and wrap upward
        sample(8'hFC, 1'b1); sample(8'hFD, 1'b1); sample(8'hFE, 1'b1);
        chk("lock_early", 32'(locked), 32'd0);
        sample(8'hFF, 1'b1);
        chk("lock_4th", 32'(locked), 32'd1);
        sample(8'h00, 1'b1);
        chk("wrap_up_locked", 32'(locked), 32'd1);
        sample(8'h01, 1'b1);
        chk("wrap_up_errs", 32'(err_count), 32'd0);

        // Lock and wrap downward
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        sample(8'h03, 1'b0); sample(8'h02, 1'b0); sample(8'h01, 1'b0); sample(8'h00, 1'b0);
        sample(8'hFF, 1'b0); sample(8'hFE, 1'b0);
        chk("wrap_dn_locked", 32'(locked), 32'd1);
        chk("wrap_dn_errs", 32'(err_count), 32'd0);

        // Glitch while locked
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        sample(8'd10, 1'b1); sample(8'd11, 1'b1); sample(8'd12, 1'b1); sample(8'd13, 1'b1);
        chk("glitch_pre_lock", 32'(locked), 32'd1);
        sample(8'd20, 1'b1);
        chk("glitch_pulse", 32'(err_pulse), 32'd1);
        chk("glitch_errs", 32'(err_count), 32'd1);
        chk("glitch_last", 32'(last_bad), 32'd20);
        chk("glitch_state", 32'(state), 32'd1);
        sample(8'd21, 1'b1);
        chk("glitch_pulse_once", 32'(err_pulse), 32'd0);
        sample(8'd22, 1'b1); sample(8'd23, 1'b1);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_state", 32'(state), 32'd2);

        // Gaps and direction change
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        sample(8'd5, 1'b1); idle(); idle();
        sample(8'd6, 1'b1); idle();
        chk("gap_state", 32'(state), 32'd1);
        sample(8'd7, 1'b1); sample(8'd8, 1'b0);
        chk("gap_locked", 32'(locked), 32'd1);
        sample(8'd7, 1'b0);
        chk("dirchg_locked", 32'(locked), 32'd1);
        chk("dirchg_errs", 32'(err_count), 32'd0);

        // Saturation: 300 discontinuities, relocking after each
        for (int i = 0; i < 300; i++) begin
            g = 8'(m_exp + int'($urandom_range(2, 254)));
            sample(g, 1'b1);
            for (int k = 0; k < LOCK_CNT - 1; k++) sample(8'(m_exp), 1'b1);
        end
        chk("sat_errs", 32'(err_count), 32'd255);
        chk("sat_locked", 32'(locked), 32'd1);
        g = 8'(m_exp + 50);
        step(1'b0, 1'b1, g, 1'b1, 1'b1);
        chk("clr_errs", 32'(err_count), 32'd0);
        chk("clr_last", 32'(last_bad), 32'd0);
        chk("clr_pulse", 32'(err_pulse), 32'd1);

        // Reset mid-lock with a coincident valid sample
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        sample(8'd40, 1'b1); sample(8'd41, 1'b1); sample(8'd42, 1'b1); sample(8'd43, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sample(8'(m_exp + 9), 1'b1);
            for (int k = 0; k < LOCK_CNT - 1; k++) sample(8'(m_exp), 1'b1);
        end
        chk("mid_locked", 32'(locked), 32'd1);
        chk("mid_errs", 32'(err_count), 32'd3);
        step(1'b1, 1'b1, 8'(m_exp + 7), 1'b1, 1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_errs", 32'(err_count), 32'd0);
        chk("rst_last", 32'(last_bad), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        sample(8'd99, 1'b1);
        chk("post_rst_seed", 32'(state), 32'd1);

        // Randomized phase, mostly following the prediction to exercise lock/relock
        for (int i = 0; i < 3000; i++) begin
            bit r, v, d, clr;
            logic [7:0] c;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 7) != 0) ? dir_up : ~dir_up;
            clr = ($urandom_range(0, 59) == 0);
            c   = ($urandom_range(0, 9) < 8) ? 8'(m_exp) : 8'($urandom_range(0, 255));
            step(r, v, c, d, clr);
        end

        idle();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Self-checking observer for the counter's parallel count output: samples the count bus, predicts the next value from the direction bit, locks after a run of consistent samples and flags, counts and captures every discontinuity once locked. It sits on the consuming end of the counter output (the reader for the counter's writer). It provides on-chip health reporting and a reusable checker for the bench.

## Interface

Parameters:
- WIDTH, 8, width of the observed count bus
- LOCK_CNT, 4, consecutive consistent samples (including the seed) required to lock; legal range 2..15
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sample_valid  input  1  count_in/dir_up are sampled this cycle
- count_in  input  WIDTH  observed counter value
- dir_up  input  1  1: next sample expected count_in+1; 0: count_in-1
- clear_err  input  1  synchronous clear of err_count and last_bad
- locked  output  1  monitor is in LOCKED state
- err_pulse  output  1  one-cycle pulse per detected discontinuity
- err_count  output  ERR_W  saturating number of discontinuities
- last_bad  output  WIDTH  count_in value of the most recent discontinuity
- state  output  2  FSM state: 0 IDLE, 1 ACQUIRE, 2 LOCKED (3 unused, recovers to IDLE)

## Operation

- Internal: expected[WIDTH], match_cnt[4].
- Prediction: on every accepted sample, expected <= dir_up ? count_in+1 : count_in-1, modulo 2^WIDTH (all-ones up -> 0, 0 down -> all-ones). Prediction always reseeds from the sample, so a single glitch produces one error, not a cascade.
- A sample "matches" when count_in == expected. Cycles with sample_valid=0 are ignored entirely: no state change, counters hold.
- IDLE: first valid sample -> seed expected, match_cnt <= 1, go ACQUIRE. No compare.
- ACQUIRE: match -> match_cnt+1. When the incremented value reaches LOCK_CNT, go LOCKED. Mismatch -> match_cnt <= 1, stay ACQUIRE, no error reported.
- LOCKED: match -> stay. Mismatch -> err_pulse, err_count+1 (saturating at all-ones), last_bad <= count_in, match_cnt <= 1, go ACQUIRE.
- dir_up is sampled per sample. A direction change is legal and produces no error, provided the sample itself matches the prediction made with the previous dir_up.
- clear_err: err_count <= 0, last_bad <= 0. Has priority over a simultaneous error increment and capture. err_pulse still fires for that error. FSM unaffected.
- Illegal state value 3 -> IDLE on next edge.

## Timing

- All outputs are registered, with no combinational input-to-output paths.
- Reset values: locked=0, err_pulse=0, err_count=0, last_bad=0, state=0 (IDLE), expected=0, match_cnt=0.
- Response to a sample at edge N is visible after edge N: new state/locked/err_pulse/err_count/last_bad.
- err_pulse is high for exactly one cycle per mismatching LOCKED sample. Back-to-back mismatches cannot pulse twice, because the first mismatch drops to ACQUIRE.
- Lock latency: locked rises after the edge sampling the LOCK_CNT-th consecutive consistent sample (seed included). With LOCK_CNT=4 and continuous valid samples, that is 4 edges after the first valid sample.
- rst asserted mid-operation: all state returns to reset values on that edge. A sample_valid coinciding with rst is discarded.
- Throughput: one sample per cycle, no backpressure.

## Test plan

- Reset/idle: assert rst 2 cycles, hold sample_valid=0 for 10 cycles -> state=0, locked=0, err_count=0, last_bad=0, err_pulse never high.
- Lock and wrap: dir_up=1, samples 0xFC,0xFD,0xFE,0xFF,0x00,0x01 every cycle -> locked=1 after the 4th sample (0xFF), stays 1 through 0x00 wrap, err_count=0. Repeat down through 0x01,0x00,0xFF -> no error.
- Glitch while locked: lock on 10,11,12,13, then send 20,21,22,23 -> single err_pulse after 20, err_count=1, last_bad=20, state=1. Relock after 23 (seed 20 + 3 matches), locked=1.
- Gaps and direction change: samples 5,6 with idle cycles between, then 7,8 (locked), dir_up=0 on sample 8, next sample 7 -> no error, locked stays 1.
- Saturation and clear: ERR_W=8, force 300 discontinuities -> err_count=255. clear_err coinciding with the next error -> err_count=0, last_bad=0, err_pulse=1 that cycle.
- Reset mid-lock: locked=1, err_count=3, assert rst with sample_valid=1 -> next cycle all outputs at reset values. The following valid sample only seeds (state=1).
